// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner. Each channel applies optional
// polarity inversion, a 2-flop synchronizer and a debounce state machine
// with a saturating qualification counter, and produces a registered
// debounced level plus one-cycle press and release pulses.
// Channel 0 is button 1, channel 1 is button 2.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn1,
   input  logic btn2,
   output logic btn1_db,
   output logic btn2_db,
   output logic btn1_press,
   output logic btn2_press,
   output logic btn1_release,
   output logic btn2_release
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } state_e;

   logic [1:0]    btn_raw;
   logic [1:0]    btn_pol;
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   state_e        state_q   [2];
   state_e        state_d   [2];
   logic [CW-1:0] cnt_q     [2];
   logic [CW-1:0] cnt_d     [2];
   logic [1:0]    db_q;
   logic [1:0]    db_d;
   logic [1:0]    press_q;
   logic [1:0]    press_d;
   logic [1:0]    release_q;
   logic [1:0]    release_d;

   // Internally 1 always means "pressed", whatever the pin polarity.
   assign btn_raw = {btn2, btn1};
   assign btn_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

   // Synchronizer, state, counter and output registers for both channels.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int ch = 0; ch < 2; ch++) begin
            state_q[ch] <= STABLE_LOW;
            cnt_q[ch]   <= '0;
         end
      end else begin
         sync1_q   <= btn_pol;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int ch = 0; ch < 2; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
         end
      end
   end

   // Debounce next-state: a new level is committed only after it has been
   // seen on sync2 for the entry cycle plus DEBOUNCE_CYCLES confirming
   // cycles; any opposite sample during the pending window rejects it.
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         state_d[ch]   = state_q[ch];
         cnt_d[ch]     = cnt_q[ch];
         db_d[ch]      = db_q[ch];
         press_d[ch]   = 1'b0;
         release_d[ch] = 1'b0;
         case (state_q[ch])
            STABLE_LOW: begin
               if (sync2_q[ch]) begin
                  state_d[ch] = PEND_HIGH;
                  cnt_d[ch]   = '0;
               end
            end
            PEND_HIGH: begin
               if (!sync2_q[ch]) begin
                  state_d[ch] = STABLE_LOW;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == CNT_MAX) begin
                  state_d[ch] = STABLE_HIGH;
                  cnt_d[ch]   = '0;
                  db_d[ch]    = 1'b1;
                  press_d[ch] = 1'b1;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end
            STABLE_HIGH: begin
               if (!sync2_q[ch]) begin
                  state_d[ch] = PEND_LOW;
                  cnt_d[ch]   = '0;
               end
            end
            PEND_LOW: begin
               if (sync2_q[ch]) begin
                  state_d[ch] = STABLE_HIGH;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == CNT_MAX) begin
                  state_d[ch]   = STABLE_LOW;
                  cnt_d[ch]     = '0;
                  db_d[ch]      = 1'b0;
                  release_d[ch] = 1'b1;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end
            default: begin
               state_d[ch] = STABLE_LOW;
               cnt_d[ch]   = '0;
            end
         endcase
      end
   end

   assign btn1_db      = db_q[0];
   assign btn2_db      = db_q[1];
   assign btn1_press   = press_q[0];
   assign btn2_press   = press_q[1];
   assign btn1_release = release_q[0];
   assign btn2_release = release_q[1];

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive clk cycles a new synchronized level must hold before it is accepted (legal range 2..2^24).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, meaning that 1 inverts both raw button inputs before synchronization (pressed = 1 internally).
REQ-003 The block SHALL have port: clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port: btn1  input  1  raw, asynchronous button 1 pin.
REQ-006 The block SHALL have port: btn2  input  1  raw, asynchronous button 2 pin.
REQ-007 The block SHALL have port: btn1_db  output  1  debounced pressed level of button 1.
REQ-008 The block SHALL have port: btn2_db  output  1  debounced pressed level of button 2.
REQ-009 The block SHALL have port: btn1_press  output  1  one-cycle pulse when btn1_db rises.
REQ-010 The block SHALL have port: btn2_press  output  1  one-cycle pulse when btn2_db rises.
REQ-011 The block SHALL have port: btn1_release  output  1  one-cycle pulse when btn1_db falls.
REQ-012 The block SHALL have port: btn2_release  output  1  one-cycle pulse when btn2_db falls.

Function
REQ-013 Each channel SHALL be independent and identical: polarity stage, 2-flop synchronizer (sync1, sync2), state machine, counter, and registered outputs.
REQ-014 The counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap, and its maximum used value SHALL be DEBOUNCE_CYCLES-1.
REQ-015 The state machine SHALL have states STABLE_LOW, PEND_HIGH, STABLE_HIGH, and PEND_LOW.
REQ-016 In STABLE_LOW with sync2=1, the channel SHALL go to PEND_HIGH with cnt=0; with sync2=0 it SHALL stay.
REQ-017 In PEND_HIGH with sync2=1 and cnt<DEBOUNCE_CYCLES-1, the channel SHALL set cnt=cnt+1.
REQ-018 In PEND_HIGH with sync2=1 and cnt=DEBOUNCE_CYCLES-1, the channel SHALL go to STABLE_HIGH with db=1, press=1 for that cycle only, and cnt=0.
REQ-019 In PEND_HIGH with sync2=0, the channel SHALL return to STABLE_LOW with cnt=0 and no output change (glitch rejected).
REQ-020 STABLE_HIGH/PEND_LOW SHALL mirror REQ-016..019 with levels inverted, ending in db=0 and release=1 for one cycle.
REQ-021 Latency: with the raw input stable from edge 0, sync1 SHALL update at edge 1, sync2 at edge 2, PEND at edge 3, and db/pulse at edge DEBOUNCE_CYCLES+3.
REQ-022 press and release SHALL never be asserted in the same cycle on one channel; each pulse SHALL last exactly one cycle.
REQ-023 Both channels MAY commit in the same cycle; their outputs SHALL then pulse simultaneously and independently.
REQ-024 A bounce train whose high intervals are all shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no db change and no pulse.
REQ-025 All outputs SHALL be driven directly from flops (no combinational path from btn* to any output).

Reset
REQ-026 While rst=1 at a rising edge, both channels SHALL load state STABLE_LOW, cnt=0, sync1=sync2=0 (post-polarity), and all six outputs SHALL be 0.
REQ-027 A reset asserted in PEND_HIGH or PEND_LOW SHALL abort the pending transition with no pulse emitted; a reset in STABLE_HIGH SHALL drop db to 0 without a release pulse.
REQ-028 After rst deasserts with a button still held, the channel SHALL re-qualify the press per REQ-021 and emit press normally.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-029 Reset, then btn1 driven 1->0 and held -> btn1_db=1 and btn1_press=1 at edge 7 only; btn2 outputs stay 0.
REQ-030 btn1 pulled low for 3 cycles and then high, repeated 5 times -> btn1_db and btn1_press stay 0 throughout.
REQ-031 btn1 pressed and stable, then released and held -> btn1_release=1 for exactly one cycle, 7 edges after the release; btn1_db=0 from that edge on.
REQ-032 btn1 and btn2 pressed on the same edge -> btn1_press=btn2_press=1 in the same cycle (edge 7).
REQ-033 btn1 pressed, rst=1 asserted at edge 5 for 1 cycle, button still held -> no pulse near edge 7; btn1_press occurs at edge 5+7=12.
REQ-034 Random bounce (1..3-cycle glitches) with constrained-random stable periods of 4 cycles or more -> the scoreboard model's db/pulse timing matches exactly, and press/release alternate strictly.
